spi_slave_mw: RTL and testbench
===============================

Name: spi_slave_mw

Overview:
- Next-generation SPI slave with parametrised word width and FIFO depth.
- SPI mode (CPOL/CPHA) and bit order are selected at run time.
- Adds sticky overflow, underflow and partial-frame error flags and FIFO level outputs.
- Oversamples sclk/cs/mosi in the system clock domain and exchanges words with the host through TX and RX FIFOs.

Parameters:
DATA_W, 8, bits per SPI word (4..32)
FIFO_DEPTH, 16, entries per TX and RX FIFO (power of two, >=2)
IDLE_WORD, 0, word shifted out when the TX FIFO is empty at word start
SYNC_STAGES, 2, synchroniser flops on sclk, cs and mosi (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sclk  in  1  SPI clock, asynchronous
cs  in  1  chip select, active low, asynchronous
mosi  in  1  master-out data
miso  out  1  slave-out data
miso_oe  out  1  high while the frame is active (cs low, synchronised)
cfg_cpol  in  1  clock idle level
cfg_cpha  in  1  0 = sample on leading edge; 1 = sample on trailing edge
cfg_lsb_first  in  1  1 = LSB first
tx_data  in  DATA_W  word to transmit
tx_wr_en  in  1  push tx_data
tx_full  out  1  TX FIFO full
tx_level  out  $clog2(FIFO_DEPTH+1)  TX occupancy
rx_data  out  DATA_W  head of RX FIFO (first-word fall-through)
rx_rd_en  in  1  pop RX head
rx_empty  out  1  RX FIFO empty
rx_level  out  $clog2(FIFO_DEPTH+1)  RX occupancy
status  out  3  sticky flags {frame_err, tx_underflow, rx_overflow}
status_clr  in  3  write-1-to-clear, per bit

Behaviour:
- Reset:
  - FIFOs emptied; miso=0, miso_oe=0, status=0, bit counter=0.
  - Synchroniser outputs forced to cs=1, sclk=cfg_cpol.
  - Levels=0, rx_empty=1, tx_full=0, rx_data=0.
  - A frame in progress is abandoned; the next frame starts only at a new cs falling edge seen after reset.
- Edge detection: the synchronised sclk is compared with its previous value. A cs falling edge (synchronised) starts a frame; a cs rising edge ends it.
- Mode latching: cfg_cpol, cfg_cpha and cfg_lsb_first are latched at the cs falling edge. Changes while cs is low are ignored.
- Edge classification: the leading edge is the transition away from the latched CPOL level; the trailing edge is the return to it. CPHA=0 samples on leading and shifts on trailing. CPHA=1 shifts on leading and samples on trailing.
- States: IDLE -> (cs fall) LOAD -> ACTIVE -> (cs rise) IDLE.
- LOAD (1 cycle):
  - Pop the TX FIFO into the shift register, or load IDLE_WORD and set tx_underflow if the FIFO is empty.
  - CPHA=0: first bit on miso at the end of LOAD.
  - CPHA=1: first bit driven on the first leading edge.
- ACTIVE:
  - Each sample edge captures mosi into the RX shift register and increments the bit counter.
  - On count DATA_W, the RX word is pushed the next cycle and the counter wraps to 0.
  - The next TX word is loaded with the same pop/underflow rule, on the same shift edge that would output bit 0 of the next word.
  - Back-to-back words need no cs toggle.
- Latency:
  - Sampled bit visible internally SYNC_STAGES+1 clk after the sclk edge.
  - RX word visible on rx_data / rx_empty=0 at most SYNC_STAGES+3 clk after the final sample edge.
  - sclk half-period must be >= SYNC_STAGES+2 clk.
- RX push while full: the word is dropped and rx_overflow is set. If rx_rd_en is asserted the same cycle, the push is accepted and no flag is set.
- TX write while full: tx_wr_en is ignored. If a shift-engine pop happens the same cycle, the write is accepted.
- Write and read to the same FIFO in one cycle: level unchanged.
- rx_rd_en while empty: ignored.
- cs rise mid-word: partial RX bits are discarded, frame_err is set, the counter is cleared, and the already-popped TX word is lost.
- status set and status_clr on the same cycle: set wins.
- miso: 0 when miso_oe=0.
- FIFO pointers: log2(FIFO_DEPTH) bits wide, plus 1 extra bit for the full/empty distinction; wrap naturally.

Decomposition:
- Package spi_pkg: mode encodings (MODE0..MODE3), status bit indices (ST_RX_OVF=0, ST_TX_UDF=1, ST_FRAME=2), state enum.
- One sub-module, sync_fifo (parametrised DATA_W, DEPTH; FWFT; level output), instantiated twice.
- The synchroniser is inline.

Test Plan:
- Mode 0, MSB first: push 0x3C; master sends 0xA5 -> rx_data=0xA5, rx_empty=0; master reads 0x3C on miso; status=0.
- Mode 3, LSB first, DATA_W=16: push 0x1234, 0xBEEF; 32-bit frame with mosi 0xCAFE,0x0001 -> RX pops 0xCAFE then 0x0001; miso 0x1234 then 0xBEEF; tx_level 2->0.
- FIFO_DEPTH=4, RX never read: 5 words sent -> rx_level=4, 5th dropped, status[0]=1; status_clr=3'b001 -> status[0]=0.
- Empty TX FIFO, IDLE_WORD=0x5A: one word exchange -> miso shifts 0x5A, status[1]=1.
- cs raised after 3 of 8 bits -> rx_empty stays 1, status[2]=1; next full frame 0x81 received correctly.
- rst pulsed mid-word (after 4 bits, TX holding 2 words) -> tx_level=0, miso=0, status=0; subsequent mode-1 frame 0x7E received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared encodings for the multi-width SPI slave: SPI modes, status flag
// positions and the frame FSM states.
package spi_pkg;

  // Encoded as {cpol, cpha}.
  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_e;

  localparam int unsigned ST_RX_OVF = 0;
  localparam int unsigned ST_TX_UDF = 1;
  localparam int unsigned ST_FRAME  = 2;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StActive
  } spi_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output. A write
// while full is accepted only if a read pops an entry in the same cycle.
module sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       full,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_ok, rd_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
  assign rd_ok   = rd_en & ~empty;
  assign wr_ok   = wr_en & (~full | rd_ok);
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign level   = wr_ptr_q - rd_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_ok};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/spi_slave_mw.sv
// SPI slave with run-time mode/bit order, oversampled in the clk domain,
// exchanging words with the host through TX and RX FIFOs.
module spi_slave_mw import spi_pkg::*; #(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       FIFO_DEPTH  = 16,
  parameter logic [DATA_W-1:0] IDLE_WORD   = '0,
  parameter int unsigned       SYNC_STAGES = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sclk,
  input  logic                            cs,
  input  logic                            mosi,
  output logic                            miso,
  output logic                            miso_oe,
  input  logic                            cfg_cpol,
  input  logic                            cfg_cpha,
  input  logic                            cfg_lsb_first,
  input  logic [DATA_W-1:0]               tx_data,
  input  logic                            tx_wr_en,
  output logic                            tx_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] tx_level,
  output logic [DATA_W-1:0]               rx_data,
  input  logic                            rx_rd_en,
  output logic                            rx_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_level,
  output logic [2:0]                      status,
  input  logic [2:0]                      status_clr
);

  localparam int unsigned     CntW    = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);
  localparam logic [CntW-1:0] AllBits = CntW'(DATA_W);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d, vld_q, vld_d;
  logic                   sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d, armed_q, armed_d;
  spi_state_e             state_q, state_d;
  spi_mode_e              mode_q, mode_d;
  logic                   lsb_q, lsb_d, rx_push_q, rx_push_d, miso_q, miso_d;
  logic                   oe_q, oe_d, udf_pend_q, udf_pend_d;
  logic [CntW-1:0]        bit_cnt_q, bit_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [DATA_W-1:0]      tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic [2:0]             status_q, status_d, set_vec;

  logic              sclk_s, cs_s, mosi_s, vld_s, cpol, cpha;
  logic              lead, trail, smp, shf, cs_fall, cs_rise;
  logic              load_req, tx_empty, rx_full;
  logic [DATA_W-1:0] tx_head, tx_word;

  function automatic logic first_bit(logic [DATA_W-1:0] w, logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(logic [DATA_W-1:0] w, logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  assign vld_s   = vld_q[SYNC_STAGES-1];
  assign cpol    = mode_q[1];
  assign cpha    = mode_q[0];
  assign lead    = (sclk_s != sclk_prev_q) && (sclk_prev_q == cpol);
  assign trail   = (sclk_s != sclk_prev_q) && (sclk_s == cpol);
  assign smp     = cpha ? trail : lead;
  assign shf     = cpha ? lead : trail;
  // Only a falling edge of a cs level genuinely seen high after reset starts a frame.
  assign cs_fall = armed_q & cs_prev_q & ~cs_s;
  assign cs_rise = ~cs_prev_q & cs_s;
  assign tx_word = tx_empty ? IDLE_WORD : tx_head;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    vld_d       = {vld_q[SYNC_STAGES-2:0], 1'b1};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    armed_d     = armed_q | (vld_s & cs_s);
    state_d     = state_q;
    mode_d      = mode_q;
    lsb_d       = lsb_q;
    bit_cnt_d   = bit_cnt_q;
    tx_cnt_d    = tx_cnt_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    rx_push_d   = 1'b0;
    miso_d      = miso_q;
    udf_pend_d  = udf_pend_q;
    load_req    = 1'b0;
    set_vec     = '0;

    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d   = StLoad;
          mode_d    = spi_mode_e'({cfg_cpol, cfg_cpha});
          lsb_d     = cfg_lsb_first;
          bit_cnt_d = '0;
        end
      end
      StLoad: begin
        load_req            = 1'b1;
        set_vec[ST_TX_UDF]  = tx_empty;
        udf_pend_d          = 1'b0;
        state_d             = StActive;
        if (cpha) begin
          tx_sh_d  = tx_word;
          tx_cnt_d = '0;
        end else begin
          miso_d   = first_bit(tx_word, lsb_q);
          tx_sh_d  = shift_out(tx_word, lsb_q);
          tx_cnt_d = CntW'(1);
        end
      end
      StActive: begin
        if (smp) begin
          rx_sh_d = lsb_q ? {mosi_s, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], mosi_s};
          // An idle word fetched mid-frame only counts as underflow once it is exchanged.
          set_vec[ST_TX_UDF] = udf_pend_q;
          udf_pend_d         = 1'b0;
          if (bit_cnt_q == LastBit) begin
            bit_cnt_d = '0;
            rx_push_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
        if (shf) begin
          if (tx_cnt_q == AllBits) begin
            load_req   = 1'b1;
            udf_pend_d = tx_empty;
            miso_d     = first_bit(tx_word, lsb_q);
            tx_sh_d    = shift_out(tx_word, lsb_q);
            tx_cnt_d   = CntW'(1);
          end else begin
            miso_d   = first_bit(tx_sh_q, lsb_q);
            tx_sh_d  = shift_out(tx_sh_q, lsb_q);
            tx_cnt_d = tx_cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if ((state_q != StIdle) && cs_rise) begin
      state_d           = StIdle;
      set_vec[ST_FRAME] = (bit_cnt_q != '0);
      bit_cnt_d         = '0;
      udf_pend_d        = 1'b0;
      miso_d            = 1'b0;
    end

    set_vec[ST_RX_OVF] = rx_push_q & rx_full & ~rx_rd_en;
    status_d           = (status_q & ~status_clr) | set_vec;
    oe_d               = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= {SYNC_STAGES{cfg_cpol}};
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      vld_q       <= '0;
      sclk_prev_q <= cfg_cpol;
      cs_prev_q   <= 1'b1;
      armed_q     <= 1'b0;
      state_q     <= StIdle;
      mode_q      <= MODE0;
      lsb_q       <= 1'b0;
      bit_cnt_q   <= '0;
      tx_cnt_q    <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      rx_push_q   <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      udf_pend_q  <= 1'b0;
      status_q    <= '0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      vld_q       <= vld_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      mode_q      <= mode_d;
      lsb_q       <= lsb_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      rx_push_q   <= rx_push_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      udf_pend_q  <= udf_pend_d;
      status_q    <= status_d;
    end
  end

  assign miso    = miso_q;
  assign miso_oe = oe_q;
  assign status  = status_q;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tx_wr_en),
    .wr_data (tx_data),
    .full    (tx_full),
    .rd_en   (load_req & ~tx_empty),
    .rd_data (tx_head),
    .empty   (tx_empty),
    .level   (tx_level)
  );

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (rx_push_q),
    .wr_data (rx_sh_q),
    .full    (rx_full),
    .rd_en   (rx_rd_en),
    .rd_data (rx_data),
    .empty   (rx_empty),
    .level   (rx_level)
  );

endmodule

// File: tb/tb_spi_slave_mw.sv
// Directed bench: an 8-bit/depth-4 slave with IDLE_WORD 0x5A and a 16-bit
// default slave share sclk/mosi, each with its own chip select.
module tb_spi_slave_mw;

  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b0, mosi = 1'b0, cs8 = 1'b1, cs16 = 1'b1;
  logic cpol = 1'b0, cpha = 1'b0, lsb = 1'b0;

  logic [7:0]  tx_data8 = '0, rx_data8;
  logic        tx_wr8 = 1'b0, rx_rd8 = 1'b0, tx_full8, rx_empty8, miso8, oe8;
  logic [2:0]  tx_level8, rx_level8, status8, clr8 = '0;
  logic [15:0] tx_data16 = '0, rx_data16;
  logic        tx_wr16 = 1'b0, rx_rd16 = 1'b0, tx_full16, rx_empty16, miso16, oe16;
  logic [4:0]  tx_level16, rx_level16;
  logic [2:0]  status16, clr16 = '0;

  logic [63:0] mi;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  spi_slave_mw #(
    .DATA_W      (8),
    .FIFO_DEPTH  (4),
    .IDLE_WORD   (8'h5A),
    .SYNC_STAGES (2)
  ) dut8 (
    .clk (clk), .rst (rst), .sclk (sclk), .cs (cs8), .mosi (mosi),
    .miso (miso8), .miso_oe (oe8),
    .cfg_cpol (cpol), .cfg_cpha (cpha), .cfg_lsb_first (lsb),
    .tx_data (tx_data8), .tx_wr_en (tx_wr8), .tx_full (tx_full8), .tx_level (tx_level8),
    .rx_data (rx_data8), .rx_rd_en (rx_rd8), .rx_empty (rx_empty8), .rx_level (rx_level8),
    .status (status8), .status_clr (clr8)
  );

  spi_slave_mw #(
    .DATA_W (16)
  ) dut16 (
    .clk (clk), .rst (rst), .sclk (sclk), .cs (cs16), .mosi (mosi),
    .miso (miso16), .miso_oe (oe16),
    .cfg_cpol (cpol), .cfg_cpha (cpha), .cfg_lsb_first (lsb),
    .tx_data (tx_data16), .tx_wr_en (tx_wr16), .tx_full (tx_full16), .tx_level (tx_level16),
    .rx_data (rx_data16), .rx_rd_en (rx_rd16), .rx_empty (rx_empty16), .rx_level (rx_level16),
    .status (status16), .status_clr (clr16)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push8(input logic [7:0] d);
    tx_data8 = d; tx_wr8 = 1'b1; cyc(1); tx_wr8 = 1'b0;
  endtask

  task automatic pop8();
    rx_rd8 = 1'b1; cyc(1); rx_rd8 = 1'b0;
  endtask

  task automatic push16(input logic [15:0] d);
    tx_data16 = d; tx_wr16 = 1'b1; cyc(1); tx_wr16 = 1'b0;
  endtask

  task automatic pop16();
    rx_rd16 = 1'b1; cyc(1); rx_rd16 = 1'b0;
  endtask

  task automatic clear8();
    clr8 = 3'b111; cyc(1); clr8 = 3'b000;
  endtask

  // Master: word k of the frame lives at bits [k*w +: w] of mo/mo_rx.
  task automatic xfer(input bit sel, input int w, input int n, input logic [63:0] mo,
                      output logic [63:0] mo_rx);
    logic [63:0] r;
    r = '0;
    sclk = cpol;
    cyc(2);
    if (sel) cs16 = 1'b0; else cs8 = 1'b0;
    cyc(HALF);
    for (int i = 0; i < n; i++) begin
      int k, j, idx;
      k = i / w;
      j = i % w;
      idx = lsb ? (k * w + j) : (k * w + w - 1 - j);
      if (!cpha) begin
        mosi = mo[idx];
        cyc(HALF);
        r[idx] = sel ? miso16 : miso8;
        sclk = ~cpol;
        cyc(HALF);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = mo[idx];
        cyc(HALF);
        r[idx] = sel ? miso16 : miso8;
        sclk = cpol;
        cyc(HALF);
      end
    end
    cyc(HALF);
    if (sel) cs16 = 1'b1; else cs8 = 1'b1;
    cyc(10);
    mo_rx = r;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc(3);
    rst = 1'b0;
    cyc(6);
    check("rst_rx_empty", rx_empty8, 1);
    check("rst_tx_level", tx_level8, 0);
    check("rst_tx_full", tx_full8, 0);
    check("rst_status", status8, 0);
    check("rst_oe", oe8, 0);
    check("rst_miso", miso8, 0);
    check("rst_rx_data", rx_data8, 0);

    // Mode 0, MSB first
    push8(8'h3C);
    check("m0_tx_level1", tx_level8, 1);
    xfer(0, 8, 8, 64'hA5, mi);
    check("m0_miso", mi, 64'h3C);
    check("m0_rx_data", rx_data8, 8'hA5);
    check("m0_rx_empty", rx_empty8, 0);
    check("m0_status", status8, 0);
    check("m0_tx_level0", tx_level8, 0);
    pop8();
    check("m0_rx_drained", rx_empty8, 1);

    // Mode 3, LSB first, 16-bit words back to back
    cpol = 1'b1; cpha = 1'b1; lsb = 1'b1;
    push16(16'h1234);
    push16(16'hBEEF);
    check("m3_tx_level2", tx_level16, 2);
    xfer(1, 16, 32, 64'h0001_CAFE, mi);
    check("m3_miso", mi, 64'hBEEF_1234);
    check("m3_tx_level0", tx_level16, 0);
    check("m3_rx_level", rx_level16, 2);
    check("m3_rx_w0", rx_data16, 16'hCAFE);
    pop16();
    check("m3_rx_w1", rx_data16, 16'h0001);
    pop16();
    check("m3_rx_empty", rx_empty16, 1);
    check("m3_status", status16, 0);

    // RX overflow on the depth-4 slave, TX empty throughout
    cpol = 1'b0; cpha = 1'b0; lsb = 1'b0;
    xfer(0, 8, 40, 64'h55_44_33_22_11, mi);
    check("ovf_miso_idle", mi, 64'h5A_5A_5A_5A_5A);
    check("ovf_rx_level", rx_level8, 4);
    check("ovf_status", status8, 3'b011);
    clr8 = 3'b001; cyc(1); clr8 = 3'b000;
    check("ovf_clr", status8, 3'b010);
    for (int i = 1; i <= 4; i++) begin
      check("ovf_rx_word", rx_data8, 64'(i * 8'h11));
      pop8();
    end
    check("ovf_rx_empty", rx_empty8, 1);
    clear8();
    check("ovf_clr_all", status8, 0);

    // Idle word on empty TX FIFO
    xfer(0, 8, 8, 64'h00, mi);
    check("udf_miso", mi, 64'h5A);
    check("udf_status", status8, 3'b010);
    check("udf_rx_data", rx_data8, 0);
    pop8();
    clear8();

    // cs raised after 3 bits, then a complete frame
    push8(8'hC3);
    xfer(0, 8, 3, 64'hFF, mi);
    check("ferr_rx_empty", rx_empty8, 1);
    check("ferr_status", status8, 3'b100);
    check("ferr_tx_lost", tx_level8, 0);
    clear8();
    xfer(0, 8, 8, 64'h81, mi);
    check("ferr_next_rx", rx_data8, 8'h81);
    check("ferr_next_miso", mi, 64'h5A);
    pop8();
    clear8();

    // Reset mid-word with two TX words queued
    push8(8'h11);
    push8(8'h22);
    check("rstmid_tx_level", tx_level8, 2);
    sclk = 1'b0;
    cs8 = 1'b0;
    cyc(HALF);
    for (int i = 0; i < 4; i++) begin
      mosi = 1'b1;
      cyc(HALF);
      sclk = 1'b1;
      cyc(HALF);
      sclk = 1'b0;
    end
    check("rstmid_oe_active", oe8, 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("rstmid_tx_level0", tx_level8, 0);
    check("rstmid_miso", miso8, 0);
    check("rstmid_status", status8, 0);
    check("rstmid_oe", oe8, 0);
    cyc(12);
    check("rstmid_no_restart", oe8, 0);
    cs8 = 1'b1;
    cyc(10);
    cpha = 1'b1;
    xfer(0, 8, 8, 64'h7E, mi);
    check("m1_rx_data", rx_data8, 8'h7E);
    check("m1_miso", mi, 64'h5A);
    check("m1_status", status8, 3'b010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
